// File: rtl/pkt_regfile_pkg.sv
// rtl/pkt_regfile_pkg.sv - shared register map, bit indices and AHB encodings
package pkt_regfile_pkg;

  localparam int unsigned OFF_CTRL      = 32'h00;
  localparam int unsigned OFF_STATUS    = 32'h04;
  localparam int unsigned OFF_DROPCNT   = 32'h08;
  localparam int unsigned OFF_PKTCNT    = 32'h0C;
  localparam int unsigned OFF_DATA_BASE = 32'h10;
  localparam int unsigned DATA_WORDS    = 8;

  localparam int unsigned CTRL_CAPEN   = 0;
  localparam int unsigned CTRL_IRQEN   = 1;
  localparam int unsigned STATUS_VALID = 0;
  localparam int unsigned STATUS_OVF   = 1;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  localparam logic [2:0] HSIZE_WORD = 3'b010;

endpackage

// File: rtl/pkt_regfile_ahb.sv
// rtl/pkt_regfile_ahb.sv - AHB-Lite data-phase register and two-cycle error response FSM
module pkt_regfile_ahb
  import pkt_regfile_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              rclk,
  input  logic              rstn,
  input  logic              hsel_i,
  input  logic [ADDR_W-1:0] haddr_i,
  input  logic [1:0]        htrans_i,
  input  logic              hwrite_i,
  input  logic [2:0]        hsize_i,
  input  logic [31:0]       hwdata_i,
  input  logic              hready_i,
  output logic              hreadyout_o,
  output logic              hresp_o,
  output logic              rd_en_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [31:0]       wdata_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ERR1 = 2'd1;
  localparam logic [1:0] ST_ERR2 = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              dph_wr_q, dph_wr_d;
  logic [ADDR_W-1:0] dph_addr_q, dph_addr_d;
  logic              xfer, legal;

  assign xfer  = hsel_i & hready_i &
                 ((htrans_i == HTRANS_NONSEQ) | (htrans_i == HTRANS_SEQ));
  assign legal = (hsize_i == HSIZE_WORD) & (haddr_i[1:0] == 2'b00);

  // ERR2 has hreadyout high, so a new address phase may be accepted there
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ERR1: state_d = ST_ERR2;
      default: state_d = (xfer & ~legal) ? ST_ERR1 : ST_IDLE;
    endcase
  end

  always_comb begin
    dph_wr_d   = dph_wr_q;
    dph_addr_d = dph_addr_q;
    if (hready_i) begin
      dph_wr_d   = xfer & legal & hwrite_i;
      dph_addr_d = haddr_i;
    end
  end

  always_ff @(posedge rclk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      dph_wr_q   <= 1'b0;
      dph_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      dph_wr_q   <= dph_wr_d;
      dph_addr_q <= dph_addr_d;
    end
  end

  assign hreadyout_o = (state_q != ST_ERR1);
  assign hresp_o     = (state_q == ST_ERR1) | (state_q == ST_ERR2);
  assign rd_en_o     = xfer & legal & ~hwrite_i;
  assign rd_addr_o   = haddr_i;
  assign wr_en_o     = dph_wr_q & hready_i;
  assign wr_addr_o   = dph_addr_q;
  assign wdata_o     = hwdata_i;

endmodule

// File: rtl/pkt_regfile.sv
// rtl/pkt_regfile.sv - single-entry packet mailbox with AHB-Lite register access
module pkt_regfile
  import pkt_regfile_pkg::*;
#(
  parameter int DCNT_W = 16,
  parameter int ADDR_W = 8
) (
  input  logic         rclk,
  input  logic         rstn,
  input  logic         pkt_valid,
  input  logic [255:0] pkt_data,
  input  logic         hsel,
  input  logic [31:0]  haddr,
  input  logic [1:0]   htrans,
  input  logic         hwrite,
  input  logic [2:0]   hsize,
  input  logic [31:0]  hwdata,
  input  logic         hready,
  output logic [31:0]  hrdata,
  output logic         hreadyout,
  output logic         hresp,
  output logic         irq
);

  localparam logic [ADDR_W-1:0] A_CTRL    = ADDR_W'(OFF_CTRL);
  localparam logic [ADDR_W-1:0] A_STATUS  = ADDR_W'(OFF_STATUS);
  localparam logic [ADDR_W-1:0] A_DROPCNT = ADDR_W'(OFF_DROPCNT);
  localparam logic [ADDR_W-1:0] A_PKTCNT  = ADDR_W'(OFF_PKTCNT);
  localparam logic [ADDR_W-1:0] A_DATA    = ADDR_W'(OFF_DATA_BASE);
  localparam logic [ADDR_W-1:0] DATA_SPAN = ADDR_W'(DATA_WORDS * 4);

  logic              rd_en, wr_en;
  logic [ADDR_W-1:0] rd_addr, wr_addr, doff;
  logic [31:0]       wdata, rd_mux;
  logic              wr_ctrl, wr_status, wr_drop;
  logic              unused_bits;

  logic [1:0]        ctrl_q, ctrl_d;
  logic              valid_q, valid_d, ovf_q, ovf_d;
  logic [DCNT_W-1:0] drop_q, drop_d;
  logic [31:0]       pktcnt_q, pktcnt_d;
  logic [255:0]      data_q, data_d;
  logic [31:0]       hrdata_q, hrdata_d;

  pkt_regfile_ahb #(.ADDR_W(ADDR_W)) u_ahb (
    .rclk        (rclk),
    .rstn        (rstn),
    .hsel_i      (hsel),
    .haddr_i     (haddr[ADDR_W-1:0]),
    .htrans_i    (htrans),
    .hwrite_i    (hwrite),
    .hsize_i     (hsize),
    .hwdata_i    (hwdata),
    .hready_i    (hready),
    .hreadyout_o (hreadyout),
    .hresp_o     (hresp),
    .rd_en_o     (rd_en),
    .rd_addr_o   (rd_addr),
    .wr_en_o     (wr_en),
    .wr_addr_o   (wr_addr),
    .wdata_o     (wdata)
  );

  assign unused_bits = ^{haddr[31:ADDR_W], wdata[31:2]};

  assign wr_ctrl   = wr_en & (wr_addr == A_CTRL);
  assign wr_status = wr_en & (wr_addr == A_STATUS);
  assign wr_drop   = wr_en & (wr_addr == A_DROPCNT);

  // Host clears are applied before capture so a same-edge clear frees the slot
  always_comb begin
    ctrl_d   = ctrl_q;
    valid_d  = valid_q;
    ovf_d    = ovf_q;
    drop_d   = drop_q;
    pktcnt_d = pktcnt_q;
    data_d   = data_q;
    if (wr_ctrl) ctrl_d = wdata[1:0];
    if (wr_status) begin
      if (!wdata[STATUS_VALID]) valid_d = 1'b0;
      if (!wdata[STATUS_OVF])   ovf_d   = 1'b0;
    end
    if (wr_drop) drop_d = '0;
    if (pkt_valid && ctrl_q[CTRL_CAPEN]) begin
      if (!valid_d) begin
        valid_d  = 1'b1;
        data_d   = pkt_data;
        pktcnt_d = pktcnt_q + 32'd1;
      end else begin
        ovf_d = 1'b1;
        if (!wr_drop && (drop_q != '1)) drop_d = drop_q + DCNT_W'(1);
      end
    end
  end

  assign doff = rd_addr - A_DATA;

  always_comb begin
    rd_mux = '0;
    if ((rd_addr >= A_DATA) && (doff < DATA_SPAN)) begin
      rd_mux = data_q[{doff[4:2], 5'b00000} +: 32];
    end else begin
      case (rd_addr)
        A_CTRL:    rd_mux = {30'b0, ctrl_q};
        A_STATUS:  rd_mux = {30'b0, ovf_q, valid_q};
        A_DROPCNT: rd_mux = 32'(drop_q);
        A_PKTCNT:  rd_mux = pktcnt_q;
        default:   rd_mux = '0;
      endcase
    end
  end

  assign hrdata_d = rd_en ? rd_mux : 32'h0;

  always_ff @(posedge rclk or negedge rstn) begin
    if (!rstn) begin
      ctrl_q   <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
      drop_q   <= '0;
      pktcnt_q <= '0;
      data_q   <= '0;
      hrdata_q <= '0;
    end else begin
      ctrl_q   <= ctrl_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
      drop_q   <= drop_d;
      pktcnt_q <= pktcnt_d;
      data_q   <= data_d;
      hrdata_q <= hrdata_d;
    end
  end

  assign hrdata = hrdata_q;
  assign irq    = valid_q & ctrl_q[CTRL_IRQEN];

endmodule
